// File: rtl/seg_scan_drv_pkg.sv
// Shared constants for the multiplexed seven-segment display path:
// digit geometry, the BCD segment table (active-low form) and idle patterns.
package seg_scan_drv_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int BCD_W      = 4;
    localparam int NUM_W      = NUM_DIGITS * BCD_W;
    localparam int IDX_W      = 3;

    // Index n holds the pattern for decimal digit n; bit 7 is the decimal point.
    localparam logic [7:0] SEG_TABLE [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [5:0] SEL_OFF = 6'h3F;

    function automatic logic is_bcd(input logic [BCD_W-1:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/seg_bcd_decode.sv
// Combinational BCD digit to seven-segment pattern; codes 10..15 show nothing.
module seg_bcd_decode
    import seg_scan_drv_pkg::*;
#(
    parameter bit ACT_LOW = 1'b1
) (
    input  logic [BCD_W-1:0] bcd,
    output logic [7:0]       seg
);

    logic [7:0] pattern;

    always_comb begin
        pattern = SEG_OFF;
        for (int i = 0; i < 10; i++) begin
            if (bcd == BCD_W'(i)) begin
                pattern = SEG_TABLE[i];
            end
        end
    end

    assign seg = ACT_LOW ? pattern : ~pattern;

endmodule

// File: rtl/seg_scan_drv.sv
// Six-digit multiplexed seven-segment driver: snapshots settled BCD values,
// scans one digit per slot with a blanking gap and optional leading-zero suppression.
module seg_scan_drv
    import seg_scan_drv_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int BLANK_CYC   = 500,
    parameter int LZ_BLANK    = 1,
    parameter int SEG_ACT_LOW = 1,
    parameter int SEL_ACT_LOW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NUM_W-1:0] num,
    input  logic             en,
    output logic [5:0]       sel,
    output logic [7:0]       seg
);

    localparam int                    CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_IDLE  = (SEG_ACT_LOW != 0) ? SEG_OFF : ~SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE  = (SEL_ACT_LOW != 0) ? SEL_OFF : ~SEL_OFF;

    logic [NUM_W-1:0]      shadow;
    logic                  valid;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;

    logic                  num_is_bcd;
    logic [NUM_DIGITS-1:0] blank;
    logic                  upper_zero;
    logic [BCD_W-1:0]      cur_digit;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] sel_onehot;
    logic [7:0]            seg_dec;
    logic                  show;

    // A single out-of-range nibble means upstream is mid-carry; skip that value.
    always_comb begin
        num_is_bcd = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!is_bcd(num[i*BCD_W +: BCD_W])) begin
                num_is_bcd = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            valid  <= 1'b0;
        end else if (en && num_is_bcd) begin
            shadow <= num;
            valid  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Walk down from the top digit; a digit is blanked while everything above it is zero.
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (shadow[i*BCD_W +: BCD_W] == '0);
            blank[i]   = upper_zero && (LZ_BLANK != 0);
        end
    end

    always_comb begin
        cur_digit  = '0;
        cur_blank  = 1'b1;
        sel_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit     = shadow[i*BCD_W +: BCD_W];
                cur_blank     = blank[i];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    seg_bcd_decode #(
        .ACT_LOW (SEG_ACT_LOW != 0)
    ) u_decode (
        .bcd (cur_digit),
        .seg (seg_dec)
    );

    assign show = valid && (cnt >= BLANK_END) && !cur_blank;

    // Registered outputs keep the pins glitch-free; they lag cnt/idx by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= SEL_IDLE;
            seg <= SEG_IDLE;
        end else if (show) begin
            sel <= (SEL_ACT_LOW != 0) ? ~sel_onehot : sel_onehot;
            seg <= seg_dec;
        end else begin
            sel <= SEL_IDLE;
            seg <= SEG_IDLE;
        end
    end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Directed bench for seg_scan_drv with SCAN_DIV=8, BLANK_CYC=2, active-low outputs;
// a second instance runs with leading-zero suppression disabled.
module tb_seg_scan_drv;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] num   = '0;
    logic        en    = 1'b0;
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic [5:0]  sel_nolz;
    logic [7:0]  seg_nolz;

    int checks = 0;
    int errors = 0;

    logic [2:0] m_cnt, m_idx;
    logic [2:0] o_cnt, o_idx;
    logic [13:0] exp_out;
    logic [13:0] exp_nolz;

    always #5 clk = ~clk;

    seg_scan_drv #(
        .SCAN_DIV    (8),
        .BLANK_CYC   (2),
        .LZ_BLANK    (1),
        .SEG_ACT_LOW (1),
        .SEL_ACT_LOW (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .num   (num),
        .en    (en),
        .sel   (sel),
        .seg   (seg)
    );

    seg_scan_drv #(
        .SCAN_DIV    (8),
        .BLANK_CYC   (2),
        .LZ_BLANK    (0),
        .SEG_ACT_LOW (1),
        .SEL_ACT_LOW (1)
    ) dut_nolz (
        .clk   (clk),
        .rst_n (rst_n),
        .num   (num),
        .en    (en),
        .sel   (sel_nolz),
        .seg   (seg_nolz)
    );

    // Slot timing reference: o_cnt/o_idx are the slot position the outputs currently show.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= '0;
            m_idx <= '0;
            o_cnt <= '0;
            o_idx <= '0;
        end else begin
            o_cnt <= m_cnt;
            o_idx <= m_idx;
            m_cnt <= (m_cnt == 3'd7) ? 3'd0 : m_cnt + 3'd1;
            if (m_cnt == 3'd7) m_idx <= (m_idx == 3'd5) ? 3'd0 : m_idx + 3'd1;
        end
    end

    // tbl holds the hand-derived pattern per digit, digit 0 in the low byte; FF = digit dark.
    function automatic logic [13:0] expect_out(input logic [47:0] tbl, input logic [2:0] i,
                                               input logic [2:0] c);
        logic [7:0] p;
        p = tbl[8*i +: 8];
        if (c < 3'd2 || p == 8'hFF) return {6'h3F, 8'hFF};
        return {~(6'b000001 << i), p};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        num   = 24'h000123;
        repeat (3) @(negedge clk);
        checks++;
        if ({sel, seg} !== {6'h3F, 8'hFF}) begin
            errors++;
            $display("[TB] FAIL reset_hold got sel=%h seg=%h want sel=3f seg=ff", sel, seg);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++;
            if ({sel, seg, sel_nolz, seg_nolz} !== {6'h3F, 8'hFF, 6'h3F, 8'hFF}) begin
                errors++;
                $display("[TB] FAIL idle_no_en cyc=%0d got sel=%h seg=%h nolz sel=%h seg=%h want 3f/ff",
                         k, sel, seg, sel_nolz, seg_nolz);
            end
        end
    endtask

    task automatic test_display_123();
        num = 24'h000123;
        en  = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            exp_out = expect_out(48'hFF_FF_FF_F9_A4_B0, o_idx, o_cnt);
            checks++;
            if ({sel, seg} !== exp_out) begin
                errors++;
                $display("[TB] FAIL show_123 idx=%0d off=%0d got sel=%h seg=%h want sel=%h seg=%h",
                         o_idx, o_cnt, sel, seg, exp_out[13:8], exp_out[7:0]);
            end
        end
    endtask

    task automatic test_invalid_bcd();
        num = 24'h00012A;
        @(negedge clk);
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            exp_out = expect_out(48'hFF_FF_FF_F9_A4_B0, o_idx, o_cnt);
            checks++;
            if ({sel, seg} !== exp_out) begin
                errors++;
                $display("[TB] FAIL hold_on_bad_bcd idx=%0d off=%0d got sel=%h seg=%h want sel=%h seg=%h",
                         o_idx, o_cnt, sel, seg, exp_out[13:8], exp_out[7:0]);
            end
        end
        num = 24'h000130;
        @(negedge clk);
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            exp_out = expect_out(48'hFF_FF_FF_F9_B0_C0, o_idx, o_cnt);
            checks++;
            if ({sel, seg} !== exp_out) begin
                errors++;
                $display("[TB] FAIL show_130 idx=%0d off=%0d got sel=%h seg=%h want sel=%h seg=%h",
                         o_idx, o_cnt, sel, seg, exp_out[13:8], exp_out[7:0]);
            end
        end
    endtask

    task automatic test_zero_value();
        num = 24'h000000;
        @(negedge clk);
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            exp_out  = expect_out(48'hFF_FF_FF_FF_FF_C0, o_idx, o_cnt);
            exp_nolz = expect_out(48'hC0_C0_C0_C0_C0_C0, o_idx, o_cnt);
            checks++;
            if ({sel, seg} !== exp_out) begin
                errors++;
                $display("[TB] FAIL zero_lz idx=%0d off=%0d got sel=%h seg=%h want sel=%h seg=%h",
                         o_idx, o_cnt, sel, seg, exp_out[13:8], exp_out[7:0]);
            end
            checks++;
            if ({sel_nolz, seg_nolz} !== exp_nolz) begin
                errors++;
                $display("[TB] FAIL zero_nolz idx=%0d off=%0d got sel=%h seg=%h want sel=%h seg=%h",
                         o_idx, o_cnt, sel_nolz, seg_nolz, exp_nolz[13:8], exp_nolz[7:0]);
            end
        end
    endtask

    task automatic test_interior_zeros();
        num = 24'h100000;
        @(negedge clk);
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            exp_out = expect_out(48'hF9_C0_C0_C0_C0_C0, o_idx, o_cnt);
            checks++;
            if ({sel, seg} !== exp_out) begin
                errors++;
                $display("[TB] FAIL interior_zero idx=%0d off=%0d got sel=%h seg=%h want sel=%h seg=%h",
                         o_idx, o_cnt, sel, seg, exp_out[13:8], exp_out[7:0]);
            end
            checks++;
            if ({sel_nolz, seg_nolz} !== exp_out) begin
                errors++;
                $display("[TB] FAIL interior_zero_nolz idx=%0d off=%0d got sel=%h seg=%h want sel=%h seg=%h",
                         o_idx, o_cnt, sel_nolz, seg_nolz, exp_out[13:8], exp_out[7:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        int guard;
        guard = 0;
        while (!(o_idx == 3'd5 && o_cnt == 3'd4) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("[TB] FAIL wait_slot5 timed out after %0d cycles", guard);
        end
        checks++;
        if ({sel, seg} !== {6'b011111, 8'hF9}) begin
            errors++;
            $display("[TB] FAIL pre_reset_active got sel=%h seg=%h want sel=1f seg=f9", sel, seg);
        end
        #1;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        checks++;
        if ({sel, seg, sel_nolz, seg_nolz} !== {6'h3F, 8'hFF, 6'h3F, 8'hFF}) begin
            errors++;
            $display("[TB] FAIL async_reset got sel=%h seg=%h nolz sel=%h seg=%h want 3f/ff",
                     sel, seg, sel_nolz, seg_nolz);
        end
        @(negedge clk);
        num   = 24'h000123;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if ({sel, seg, sel_nolz, seg_nolz} !== {6'h3F, 8'hFF, 6'h3F, 8'hFF}) begin
                errors++;
                $display("[TB] FAIL post_reset_dark cyc=%0d got sel=%h seg=%h nolz sel=%h seg=%h want 3f/ff",
                         k, sel, seg, sel_nolz, seg_nolz);
            end
        end
        en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            exp_out = expect_out(48'hFF_FF_FF_F9_A4_B0, o_idx, o_cnt);
            checks++;
            if ({sel, seg} !== exp_out) begin
                errors++;
                $display("[TB] FAIL restart_scan idx=%0d off=%0d got sel=%h seg=%h want sel=%h seg=%h",
                         o_idx, o_cnt, sel, seg, exp_out[13:8], exp_out[7:0]);
            end
        end
    endtask

    initial begin
        $display("[TB] seg_scan_drv directed bench start");
        test_reset();
        test_display_123();
        test_invalid_bcd();
        test_zero_value();
        test_interior_zeros();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_drv.md
Name: seg_scan_drv

Overview:
- Downstream consumer of the key-driven BCD counter. Takes its 24-bit, 6-digit BCD value `num` and the `en` qualifier.
- Drives a 6-digit multiplexed seven-segment display: time-division digit scan, per-digit anti-ghost blanking, leading-zero suppression.
- Snapshots only settled BCD values, so carry-normalisation transients from upstream never reach the display.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (1 kHz per digit at 50 MHz); minimum 4.
- BLANK_CYC, 500, cycles at the start of each slot with all digits off; must be < SCAN_DIV.
- LZ_BLANK, 1, 1 = suppress leading zeros (digit 0 always shown); 0 = show all six digits.
- SEG_ACT_LOW, 1, 1 = segment lines active low.
- SEL_ACT_LOW, 1, 1 = digit-select lines active low.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- num  in  24  six BCD digits; num[3:0] = digit 0 (least significant), num[23:20] = digit 5
- en  in  1  upstream value-valid level; high once upstream has been updated after reset
- sel  out  6  digit enables; sel[i] drives digit i
- seg  out  8  seg[6:0] = segments g..a, seg[7] = decimal point (always off)

Behaviour:
- Reset (async, rst_n=0):
  - sel = all-off (6'h3F when active low); seg = all-off (8'hFF when active low).
  - shadow = 0, valid = 0, cnt = 0, idx = 0.
  - Takes effect immediately, including mid-slot.
- Snapshot:
  - Condition: en=1 and every nibble of num is ≤ 9.
  - Effect: shadow <= num and valid <= 1 on that edge.
  - Otherwise shadow and valid hold. Any nibble of 10..15 blocks the whole snapshot, even with en=1.
  - valid never clears except by reset.
- Prescaler:
  - cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - On the edge where cnt == SCAN_DIV-1, idx advances 0→1→…→5→0.
- Blank mask, computed combinationally from shadow:
  - If LZ_BLANK=1: digit i (i ≥ 1) is blanked iff shadow digits i..5 are all zero.
  - Digit 0 is never blanked by this rule.
  - Zeros below the highest nonzero digit are displayed.
- Output registers, updated every edge from the current cnt, idx and shadow:
  - If valid=0, or cnt < BLANK_CYC, or digit idx is blanked: sel and seg are all-off.
  - Otherwise: only sel[idx] is active, and seg = decode(shadow digit idx).
  - Never more than one sel bit active.
- Latency:
  - Outputs lag (cnt, idx) by one cycle.
  - A new snapshot appears when its digit is next driven, at most 6·SCAN_DIV+1 cycles later.
- Decode table (active-low form, dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Active-high form is the bitwise complement.
  - Unreachable codes 10..15 decode to all-off.
- Simultaneous snapshot and slot change: both occur; the new slot uses the updated shadow from the next cycle on. The first BLANK_CYC cycles are off anyway.

Decomposition:
- Shared package holds:
  - NUM_DIGITS = 6
  - BCD_W = 4
  - the 10-entry seven-segment constant table (active-low form)
  - SEG_OFF and SEL_OFF constants
- One sub-module, seg_bcd_decode: combinational 4-bit BCD to 8-bit segment pattern with a polarity parameter.
  - Instantiated once on the muxed digit.
  - Also reusable by other display blocks.

Test Plan (SCAN_DIV=8, BLANK_CYC=2, active-low):
1. Reset released with en=0 for 100 cycles → sel=6'h3F and seg=8'hFF throughout; never any active digit.
2. num=24'h000123, en=1 → per 48-cycle frame:
   - digit 0: sel=6'b111110, seg=B0 for cycle offsets 2..7 of its slot;
   - digit 1: A4;
   - digit 2: F9;
   - slots 3..5 all-off;
   - cycle offsets 0..1 of every slot are all-off.
3. After step 2, num=24'h00012A with en=1 → shadow unchanged and display still shows 123; then num=24'h000130 → display shows 130 (digit 0 = C0).
4. LZ_BLANK=0, num=0, en=1 → all six digits show C0 in turn, with exactly one sel bit low per slot.
5. num=24'h100000 → digits 0..4 show C0 and digit 5 shows F9 (interior zeros not suppressed).
6. rst_n asserted mid-slot while a digit is active → sel/seg go off asynchronously in the same cycle; after release, display stays off until the next valid snapshot, and the scan restarts at idx=0, cnt=0.
